tdm_demux: RTL and testbench



---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_counter.sv | 45 ++++
 rtl/tdm_demux.sv | 176 +++++++++++++++++
 tb/tb_tdm_demux.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM mux/demux pair.
// Contents: default channel/beat sizes, demux FSM state type, slot-width helper.
package tdm_pkg;

  localparam int unsigned TDM_CHANNELS = 4;
  localparam int unsigned TDM_WIDTH    = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // Width of a slot index for n slots; never less than one bit.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index for the TDM demux, range 0..CHANNELS-1.
// Ports:
//   clk, rst   clock, async active-high reset (slot -> 0)
//   i_clear    slot <- 0 (highest priority)
//   i_load1    slot <- 1
//   i_incr     slot <- slot+1, or 0 when at CHANNELS-1
//   o_slot     current slot (registered)
//   o_wrap_c   slot == CHANNELS-1 (combinational)
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SLOT_W   = slot_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load1,
  input  logic              i_incr,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_wrap_c
);

  logic [SLOT_W-1:0] r_slot;
  logic              w_wrap;

  // Explicit last-slot compare so non-power-of-two frames wrap correctly.
  assign w_wrap = (r_slot == SLOT_W'(CHANNELS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
    end else if (i_load1) begin
      r_slot <= SLOT_W'(1);
    end else if (i_incr) begin
      r_slot <= w_wrap ? '0 : r_slot + SLOT_W'(1);
    end
  end

  assign o_slot   = r_slot;
  assign o_wrap_c = w_wrap;

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer. Routes each valid beat of a framed
// serial stream to its channel register, tracks frame alignment, flags errors.
// Option: define TDM_DEMUX_FRAME_BUFFER_EN to stage beats in a shadow bank and
// publish all channels at once when a frame completes.
// Ports:
//   clk, rst     clock, async active-high reset
//   din          beat data (WIDTH)
//   din_valid    beat present
//   frame_sync   beat is slot 0 (qualified by din_valid)
//   ch_data      channel k at [k*WIDTH +: WIDTH]
//   ch_strobe    per-channel update pulse
//   frame_done   pulse when the last slot is captured
//   locked       aligned to the frame
//   sync_err     pulse on an alignment error
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned WIDTH    = TDM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] ch_data,
  output logic [CHANNELS-1:0]       ch_strobe,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      sync_err
);

  localparam int unsigned SW = slot_width(CHANNELS);

  tdm_state_e        r_state;
  tdm_state_e        w_state_next;
  logic [SW-1:0]     w_slot;
  logic              w_wrap;
  logic              w_capture;
  logic              w_cap_ch0;
  logic [SW-1:0]     w_cap_idx;
  logic              w_sync_err;
  logic              w_frame_done;
  logic              w_cnt_clear;
  logic              w_cnt_load1;
  logic              w_cnt_incr;

  logic [WIDTH-1:0]    r_ch [CHANNELS];
  logic [CHANNELS-1:0] r_strobe;
  logic                r_frame_done;
  logic                r_locked;
  logic                r_sync_err;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SLOT_W   (SW)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cnt_clear),
    .i_load1  (w_cnt_load1),
    .i_incr   (w_cnt_incr),
    .o_slot   (w_slot),
    .o_wrap_c (w_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_next;
  end

  // Next-state and per-beat control decode.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_cap_ch0    = 1'b0;
    w_sync_err   = 1'b0;
    w_frame_done = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_load1  = 1'b0;
    w_cnt_incr   = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_sync) begin
            w_capture    = 1'b1;
            w_cap_ch0    = 1'b1;
            w_cnt_load1  = 1'b1;
            w_state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Sync always restarts the frame; mid-frame sync is an error.
            w_capture   = 1'b1;
            w_cap_ch0   = 1'b1;
            w_cnt_load1 = 1'b1;
            w_sync_err  = (w_slot != '0);
          end else if (w_slot == '0) begin
            // Expected sync is missing: drop the beat and re-acquire.
            w_sync_err   = 1'b1;
            w_cnt_clear  = 1'b1;
            w_state_next = HUNT;
          end else begin
            w_capture    = 1'b1;
            w_cnt_incr   = 1'b1;
            w_frame_done = w_wrap;
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  assign w_cap_idx = w_cap_ch0 ? '0 : w_slot;

  // Status pulses and lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_frame_done <= w_frame_done;
      r_sync_err   <= w_sync_err;
      r_locked     <= (w_state_next == LOCKED);
    end
  end

`ifdef TDM_DEMUX_FRAME_BUFFER_EN
  logic [WIDTH-1:0] r_shadow [CHANNELS];

  // Beats collect in the shadow bank; a completed frame is published at once.
  // A broken frame needs no explicit flush: publishing requires a fresh sync
  // followed by every remaining slot, which overwrites the whole bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe <= '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_shadow[k] <= '0;
        r_ch[k]     <= '0;
      end
    end else begin
      r_strobe <= w_frame_done ? '1 : '0;
      for (int k = 0; k < int'(CHANNELS); k++) begin
        if (w_capture && (w_cap_idx == SW'(k))) r_shadow[k] <= din;
        if (w_frame_done) r_ch[k] <= (k == int'(CHANNELS) - 1) ? din : r_shadow[k];
      end
    end
  end
`else
  // Each beat updates its channel register directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strobe <= '0;
      for (int k = 0; k < int'(CHANNELS); k++) r_ch[k] <= '0;
    end else begin
      for (int k = 0; k < int'(CHANNELS); k++) begin
        r_strobe[k] <= w_capture && (w_cap_idx == SW'(k));
        if (w_capture && (w_cap_idx == SW'(k))) r_ch[k] <= din;
      end
    end
  end
`endif

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_pack
    assign ch_data[g*WIDTH +: WIDTH] = r_ch[g];
  end

  assign ch_strobe  = r_strobe;
  assign frame_done = r_frame_done;
  assign locked     = r_locked;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: self-checking bench for tdm_demux (CHANNELS=4, WIDTH=8).
// Follows TDM_DEMUX_FRAME_BUFFER_EN in the same way as the design.
module tb_tdm_demux;

  localparam int C = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [C*W-1:0] ch_data;
  logic [C-1:0]   ch_strobe;
  logic           frame_done;
  logic           locked;
  logic           sync_err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what the outputs must show after the latest edge.
  logic         m_locked;
  int           m_slot;
  logic [W-1:0] m_ch [C];
  logic [W-1:0] m_sh [C];
  logic [C-1:0] m_strobe;
  logic         m_fd;
  logic         m_err;

  always #5 clk = ~clk;

  tdm_demux #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_strobe  (ch_strobe),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  function automatic logic [C*W-1:0] exp_data();
    logic [C*W-1:0] e;
    for (int k = 0; k < C; k++) e[k*W +: W] = m_ch[k];
    return e;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_slot   = 0;
    m_strobe = '0;
    m_fd     = 1'b0;
    m_err    = 1'b0;
    for (int k = 0; k < C; k++) begin
      m_ch[k] = '0;
      m_sh[k] = '0;
    end
  endtask

  // Store a beat for slot k: directly, or into the frame buffer.
  task automatic model_put(input int k, input logic [W-1:0] d);
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
    m_sh[k] = d;
`else
    m_ch[k] = d;
    m_strobe[k] = 1'b1;
`endif
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    m_strobe = '0;
    m_fd     = 1'b0;
    m_err    = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          model_put(0, d);
          m_slot = 1;
          m_locked = 1'b1;
        end
      end else if (s) begin
        m_err = (m_slot != 0);
        model_put(0, d);
        m_slot = 1;
      end else if (m_slot == 0) begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end else begin
        model_put(m_slot, d);
        if (m_slot == C - 1) begin
          m_fd = 1'b1;
          m_slot = 0;
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
          for (int k = 0; k < C; k++) m_ch[k] = m_sh[k];
          m_strobe = '1;
`endif
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
  endtask

  // Present one cycle of input, update the model at the edge, settle.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if ({ch_data, ch_strobe, frame_done, locked, sync_err} !== '0) begin
      n_err++;
      $display("FAIL reset: got data=%h strb=%b fd=%b lk=%b err=%b want all zero",
               ch_data, ch_strobe, frame_done, locked, sync_err);
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] d;
    for (int i = 0; i < C; i++) begin
      d = W'(8'hA0 + i);
      drive(1'b1, (i == 0), d);
      n_chk++;
      if ({ch_data, ch_strobe, frame_done, locked, sync_err} !==
          {exp_data(), m_strobe, m_fd, m_locked, m_err}) begin
        n_err++;
        $display("FAIL frame beat%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                 ch_data, ch_strobe, frame_done, locked, sync_err,
                 exp_data(), m_strobe, m_fd, m_locked, m_err);
      end
    end
    n_chk++;
    if (ch_data !== 32'hA3A2A1A0 || frame_done !== 1'b1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL frame_end: got data=%h fd=%b lk=%b want A3A2A1A0/1/1",
               ch_data, frame_done, locked);
    end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    drive(1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (ch_data !== '0 || ch_strobe !== '0 || locked !== 1'b0 || sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL hunt_drop: got data=%h strb=%b lk=%b err=%b want 0/0/0/0",
               ch_data, ch_strobe, locked, sync_err);
    end
  endtask

  // Starts from a locked, slot-0 state left by test_frame.
  task automatic test_early_sync();
    logic [W-1:0] beats [7] = '{8'h50, 8'h51, 8'h55, 8'h66, 8'h67, 8'h68, 8'h00};
    logic         syncs [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, syncs[i], beats[i]);
      n_chk++;
      if ({ch_data, ch_strobe, frame_done, locked, sync_err} !==
          {exp_data(), m_strobe, m_fd, m_locked, m_err}) begin
        n_err++;
        $display("FAIL early_sync beat%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                 ch_data, ch_strobe, frame_done, locked, sync_err,
                 exp_data(), m_strobe, m_fd, m_locked, m_err);
      end
      if (i == 2) begin
        n_chk++;
`ifdef TDM_DEMUX_FRAME_BUFFER_EN
        if (sync_err !== 1'b1 || ch_data[7:0] !== 8'hA0) begin
`else
        if (sync_err !== 1'b1 || ch_data[7:0] !== 8'h55) begin
`endif
          n_err++;
          $display("FAIL early_sync_err: got err=%b ch0=%h", sync_err, ch_data[7:0]);
        end
      end
    end
    n_chk++;
    if (ch_data !== 32'h68676655) begin
      n_err++;
      $display("FAIL early_sync_end: got %h want 68676655", ch_data);
    end
  endtask

  task automatic test_missing_sync();
    drive(1'b1, 1'b0, 8'h77);
    n_chk++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_strobe !== '0 ||
        ch_data !== 32'h68676655) begin
      n_err++;
      $display("FAIL missing_sync: got err=%b lk=%b strb=%b data=%h want 1/0/0/68676655",
               sync_err, locked, ch_strobe, ch_data);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (sync_err !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL missing_sync_after: got err=%b lk=%b want 0/0", sync_err, locked);
    end
  endtask

  task automatic test_idle_gaps();
    int gaps [C] = '{1, 2, 1, 0};
    int n_fd = 0;
    do_reset();
    for (int i = 0; i < C; i++) begin
      drive(1'b1, (i == 0), W'(8'hB0 + i));
      n_fd += int'(frame_done);
      for (int g = 0; g < gaps[i]; g++) begin
        drive(1'b0, 1'b1, 8'hFF);
        n_chk++;
        if ({ch_data, ch_strobe, frame_done, locked, sync_err} !==
            {exp_data(), m_strobe, m_fd, m_locked, m_err}) begin
          n_err++;
          $display("FAIL idle beat%0d gap%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i, g,
                   ch_data, ch_strobe, frame_done, locked, sync_err,
                   exp_data(), m_strobe, m_fd, m_locked, m_err);
        end
      end
    end
    n_chk++;
    if (ch_data !== 32'hB3B2B1B0 || n_fd != 1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL idle_end: got data=%h fd_count=%0d lk=%b want B3B2B1B0/1/1",
               ch_data, n_fd, locked);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 1'b1, 8'hC0);
    drive(1'b1, 1'b0, 8'hC1);
    drive(1'b1, 1'b0, 8'hC2);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({ch_data, ch_strobe, frame_done, locked, sync_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got data=%h strb=%b fd=%b lk=%b err=%b want all zero",
               ch_data, ch_strobe, frame_done, locked, sync_err);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < C; i++) drive(1'b1, (i == 0), W'(8'hD0 + i));
    n_chk++;
    if (ch_data !== 32'hD3D2D1D0 || frame_done !== 1'b1 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_frame: got data=%h fd=%b lk=%b want D3D2D1D0/1/1",
               ch_data, frame_done, locked);
    end
  endtask

  // Mostly well-framed random stream with occasional sync faults and idles.
  task automatic test_random();
    int   tx_slot = 0;
    logic v, s;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(9) < 7);
      s = (tx_slot == 0);
      if ($urandom_range(11) == 0) s = ~s;
      drive(v, s, W'($urandom));
      if (v) tx_slot = (tx_slot + 1) % C;
      n_chk++;
      if ({ch_data, ch_strobe, frame_done, locked, sync_err} !==
          {exp_data(), m_strobe, m_fd, m_locked, m_err}) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", n,
                 ch_data, ch_strobe, frame_done, locked, sync_err,
                 exp_data(), m_strobe, m_fd, m_locked, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame();
    test_early_sync();
    test_missing_sync();
    test_hunt_drop();
    test_idle_gaps();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
